// File: rtl/branch_pattern_table.sv
// Gshare pattern history table: 2-bit counters indexed by PC XOR global history,
// registered lookups with write bypass, and a two-stage read-modify-write update path.
module branch_pattern_table #(
    parameter int          INDEX_BITS = 6,
    parameter int          PC_WIDTH   = 32,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_out_valid,
    output logic                  pred_taken,
    output logic [1:0]            pred_state,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic [1:0]            ctr_curr_state,
    output logic                  ctr_actual_taken,
    input  logic [1:0]            ctr_next_state
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] sweep;
    logic [INDEX_BITS-1:0] ghr;
    logic                  upd_q_valid;
    logic [INDEX_BITS-1:0] upd_q_index;
    logic                  upd_q_taken;
    logic [1:0]            table_q [ENTRIES];

    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            lookup_state;
    logic                  unused_pc_bits;

    // Only the word-aligned low PC bits above the byte offset feed the index.
    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0]};

    always_comb begin
        lookup_index = pred_pc[INDEX_BITS+1:2] ^ ghr;
        // A write landing on the looked-up entry at this edge is forwarded.
        if (upd_q_valid && (upd_q_index == lookup_index)) begin
            lookup_state = ctr_next_state;
        end else begin
            lookup_state = table_q[lookup_index];
        end
    end

    assign ctr_curr_state   = upd_q_valid ? table_q[upd_q_index] : 2'b00;
    assign ctr_actual_taken = upd_q_valid ? upd_q_taken : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            sweep          <= '0;
            ghr            <= '0;
            upd_q_valid    <= 1'b0;
            upd_q_index    <= '0;
            upd_q_taken    <= 1'b0;
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_state     <= 2'b00;
            pred_index     <= '0;
            ready          <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    table_q[sweep] <= INIT_STATE;
                    sweep          <= sweep + 1'b1;
                    upd_q_valid    <= 1'b0;
                    pred_out_valid <= 1'b0;
                    if (sweep == INDEX_BITS'(ENTRIES - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (upd_q_valid) begin
                        table_q[upd_q_index] <= ctr_next_state;
                    end
                    upd_q_valid <= upd_valid;
                    if (upd_valid) begin
                        upd_q_index <= upd_index;
                        upd_q_taken <= upd_taken;
                        ghr         <= {ghr[INDEX_BITS-2:0], upd_taken};
                    end
                    pred_out_valid <= pred_valid;
                    if (pred_valid) begin
                        pred_state <= lookup_state;
                        pred_taken <= lookup_state[1];
                        pred_index <= lookup_index;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_pattern_table.sv
// Directed bench for branch_pattern_table: init sweep, training, saturation,
// bypass, mid-operation reset and not-ready gating.
module tb_branch_pattern_table;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_out_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic [5:0]  pred_index;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic [1:0]  ctr_curr_state;
    logic        ctr_actual_taken;
    logic [1:0]  ctr_next_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] ghr_m;

    always #5 clk = ~clk;

    branch_pattern_table dut (
        .clk              (clk),
        .rst              (rst),
        .ready            (ready),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_out_valid   (pred_out_valid),
        .pred_taken       (pred_taken),
        .pred_state       (pred_state),
        .pred_index       (pred_index),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .ctr_curr_state   (ctr_curr_state),
        .ctr_actual_taken (ctr_actual_taken),
        .ctr_next_state   (ctr_next_state)
    );

    // Stand-in for the external saturating counter next-state block.
    function automatic logic [1:0] sat_next(input logic [1:0] s, input logic t);
        if (t) return (s == 2'b11) ? 2'b11 : s + 2'b01;
        else   return (s == 2'b00) ? 2'b00 : s - 2'b01;
    endfunction

    assign ctr_next_state = sat_next(ctr_curr_state, ctr_actual_taken);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [5:0] exp_idx,
                          input logic [1:0] exp_state, input string tag);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        pred_valid = 1'b0;
        check({tag, "_valid"}, pred_out_valid, 1);
        check({tag, "_state"}, pred_state, exp_state);
        check({tag, "_taken"}, pred_taken, exp_state[1]);
        check({tag, "_index"}, pred_index, exp_idx);
    endtask

    task automatic wait_ready(input string tag, input logic inject);
        int  cnt;
        logic bad;
        cnt = 0;
        bad = 1'b0;
        while (!ready && cnt < 200) begin
            if (inject && cnt == 10) begin
                pred_valid = 1'b1;
                pred_pc    = 32'h100;
                upd_valid  = 1'b1;
                upd_index  = 6'd3;
                upd_taken  = 1'b1;
            end else begin
                pred_valid = 1'b0;
                upd_valid  = 1'b0;
            end
            tick();
            cnt++;
            if (pred_out_valid !== 1'b0 || ctr_curr_state !== 2'b00) bad = 1'b1;
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        check({tag, "_edges"}, cnt, 64);
        check({tag, "_quiet"}, bad, 0);
    endtask

    logic [1:0] down_exp [4];

    initial begin
        down_exp   = '{2'b10, 2'b01, 2'b00, 2'b00};
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_pc    = '0;
        upd_valid  = 1'b0;
        upd_index  = '0;
        upd_taken  = 1'b0;
        ghr_m      = '0;
        repeat (3) tick();

        check("rst_ready", ready, 0);
        check("rst_pov", pred_out_valid, 0);
        check("rst_taken", pred_taken, 0);
        check("rst_state", pred_state, 0);
        check("rst_index", pred_index, 0);
        check("rst_ctr_curr", ctr_curr_state, 0);
        check("rst_ctr_taken", ctr_actual_taken, 0);

        // Sweep with requests pulsed while not ready; they must be ignored.
        rst = 1'b0;
        wait_ready("init", 1'b1);
        lookup(32'h100, 6'h00, 2'b01, "first");
        tick();
        check("idle_pov", pred_out_valid, 0);

        // Training on index 5 with a bypassed lookup at the first write edge.
        upd_valid = 1'b1;
        upd_index = 6'd5;
        upd_taken = 1'b1;
        tick();
        check("tr1_curr", ctr_curr_state, 2'b01);
        check("tr1_act", ctr_actual_taken, 1);
        pred_valid = 1'b1;
        pred_pc    = 32'h10;
        tick();
        pred_valid = 1'b0;
        check("bypass_valid", pred_out_valid, 1);
        check("bypass_state", pred_state, 2'b10);
        check("bypass_taken", pred_taken, 1);
        check("bypass_index", pred_index, 6'd5);
        check("tr2_curr", ctr_curr_state, 2'b10);
        tick();
        upd_valid = 1'b0;
        check("tr3_curr", ctr_curr_state, 2'b11);
        tick();
        check("tr_idle_curr", ctr_curr_state, 2'b00);
        check("tr_idle_act", ctr_actual_taken, 0);
        ghr_m = 6'b000111;
        lookup(32'h08, 6'd5, 2'b11, "trained");

        // Saturate down with four not-taken resolutions.
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_index = 6'd5;
            upd_taken = 1'b0;
            tick();
            upd_valid = 1'b0;
            ghr_m = {ghr_m[4:0], 1'b0};
            tick();
            lookup({24'b0, 6'd5 ^ ghr_m, 2'b00}, 6'd5, down_exp[i], "down");
        end

        // Reset while an update is in stage 1 and a lookup result is showing.
        upd_valid  = 1'b1;
        upd_index  = 6'd5;
        upd_taken  = 1'b1;
        pred_valid = 1'b1;
        pred_pc    = 32'h0;
        tick();
        check("mid_curr", ctr_curr_state, 2'b00);
        check("mid_act", ctr_actual_taken, 1);
        check("mid_pov", pred_out_valid, 1);
        rst        = 1'b1;
        upd_valid  = 1'b0;
        pred_valid = 1'b0;
        tick();
        check("mrst_ready", ready, 0);
        check("mrst_pov", pred_out_valid, 0);
        check("mrst_state", pred_state, 0);
        check("mrst_index", pred_index, 0);
        check("mrst_curr", ctr_curr_state, 0);
        check("mrst_act", ctr_actual_taken, 0);
        rst = 1'b0;
        wait_ready("reinit", 1'b0);
        ghr_m = '0;
        for (int i = 0; i < 64; i++) begin
            lookup({24'b0, 6'(i), 2'b00}, 6'(i), 2'b01, "sweep_rd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_pattern_table.md
# branch_pattern_table

Pattern history table (PHT) for the dynamic branch predictor, using gshare indexing: PC bits XOR global history. It stores one 2-bit saturating counter per entry and answers fetch-stage lookups with a registered prediction. At branch resolution it performs a read-modify-write of the entry. The read value goes to the external 2-bit counter next-state block, and that block's result is written back. The block sits directly upstream of the counter block: it supplies the current state and the resolved outcome, and consumes the next state.

## Interface
- INDEX_BITS, 6: table has 2^INDEX_BITS entries; global history register (GHR) width equals INDEX_BITS
- PC_WIDTH, 32: width of the lookup PC
- INIT_STATE, 2'b01: value written to every entry by the init sweep (weakly not-taken)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once init sweep completes; requests ignored while low
- pred_valid  in  1  lookup request this cycle
- pred_pc  in  PC_WIDTH  branch PC to look up
- pred_out_valid  out  1  registered: lookup result valid this cycle
- pred_taken  out  1  registered: MSB of looked-up counter
- pred_state  out  2  registered: looked-up counter value
- pred_index  out  INDEX_BITS  registered: index used; returned later on upd_index
- upd_valid  in  1  resolved-branch update request
- upd_index  in  INDEX_BITS  index from the original prediction
- upd_taken  in  1  resolved direction
- ctr_curr_state  out  2  to counter block: entry being updated
- ctr_actual_taken  out  1  to counter block: resolved direction
- ctr_next_state  in  2  from counter block: new entry value (combinational return path)

## Operation
- Index = pred_pc[INDEX_BITS+1:2] XOR GHR, using the GHR value before any update at the same edge.
- Control FSM, two states:
  - INIT: entered on rst. Sweep counter is reset to 0. On each edge with rst low, table[sweep] <= INIT_STATE and sweep increments. After entry 2^INDEX_BITS-1 is written, the FSM goes to RUN.
  - RUN: ready=1. The block stays in RUN until rst.
- rst at any time, including mid-update or mid-sweep:
  - FSM to INIT, sweep to 0
  - GHR to 0
  - update stage invalid
  - pred_out_valid, pred_taken, pred_state and pred_index to 0
  - ready to 0
  - The table is re-initialised by the new sweep.
- Lookup, in RUN with pred_valid=1 at edge E: from the next cycle, pred_out_valid=1 and pred_state=table[index]. If the update stage writes the same index at edge E, pred_state shows that new ctr_next_state value (bypass). pred_taken=pred_state[1]. pred_index=index. pred_out_valid=0 when there is no accepted lookup.
- Update stage 0, in RUN with upd_valid=1 at edge E:
  - Capture upd_q_valid=1, upd_q_index=upd_index and upd_q_taken=upd_taken.
  - GHR <= {GHR[INDEX_BITS-2:0], upd_taken}. The GHR is updated non-speculatively.
- Update stage 1, the cycle with upd_q_valid=1:
  - ctr_curr_state=table[upd_q_index], ctr_actual_taken=upd_q_taken.
  - At the closing edge, table[upd_q_index] <= ctr_next_state.
  - When upd_q_valid=0, ctr_curr_state=0 and ctr_actual_taken=0, and no write occurs.
- Back-to-back updates to the same index need no stall. Each write completes before the next read.
- A lookup and an update in the same cycle are both accepted.
- pred_valid and upd_valid are ignored while ready=0.

## Timing
- Lookup latency: 1 cycle, request edge to pred_out_valid.
- Update: entry written at the 2nd edge after upd_valid is sampled. The GHR changes at the 1st edge.
- ready rises 2^INDEX_BITS edges after the first edge with rst low. With the default, that is 64 edges.
- Throughput: one lookup and one update per cycle, sustained.
- Reset values: ready 0, pred_out_valid 0, pred_taken 0, pred_state 0, pred_index 0, ctr_curr_state 0, ctr_actual_taken 0, GHR 0.

## Test plan
- Init sweep: hold rst 3 cycles, then release. ready=0 for 64 edges, then 1. A lookup of pc=0x100 returns pred_state=01, pred_taken=0, pred_index=0x00.
- Training: issue 3 taken updates to index 5, back-to-back. Entry 5 goes 01→10→11→11, and the GHR becomes 000111. A lookup of pc=0x08 (0b000010 XOR 0b000111 = 5) returns pred_state=11, pred_taken=1, pred_index=5.
- Saturate down: starting from entry 5 = 11, issue 4 not-taken updates. The entry reads 10, 01, 00, 00 after each write completes.
- Bypass: time a lookup to index 5 at the same edge as the write of 10 over 01. pred_state=10 in the next cycle.
- Mid-operation reset: after training, assert rst in the cycle where upd_q_valid=1. No write lands. ready, pred_out_valid and the GHR all go to 0. After 64 edges, every index reads 01.
- Not-ready gating: pulse pred_valid and upd_valid during the sweep. pred_out_valid stays 0, the GHR stays 0, and all entries read 01 after ready rises.
